clic_irq_target: RTL and testbench
==================================

# clic_irq_target

Core-side receiver for the CLIC interrupt handshake. Consumes the `irq_valid/irq_ready/irq_id/irq_level/irq_shv` stream driven by `clic`, filters each request against the current interrupt level and the threshold, and hands accepted interrupts to the hart with a request/acknowledge pair. It tracks preemption nesting with a level stack that `mret` pops, and sits between `clic` and the core's trap logic.

## Interface
- `N_SOURCE`, 256: number of interrupt sources; must match `clic`.
- `SRC_W`, $clog2(N_SOURCE): width of interrupt id.
- `STACK_DEPTH`, 4: maximum nesting depth, ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `irq_valid_i`  in  1  CLIC interrupt request valid.
- `irq_ready_o`  out  1  request accepted this cycle.
- `irq_id_i`  in  SRC_W  interrupt id.
- `irq_level_i`  in  8  interrupt level.
- `irq_shv_i`  in  1  selective hardware vectoring.
- `mintthresh_i`  in  8  threshold; only levels above it are taken.
- `core_irq_req_o`  out  1  trap request to core.
- `core_irq_id_o`  out  SRC_W  latched id.
- `core_irq_level_o`  out  8  latched level.
- `core_irq_shv_o`  out  1  latched shv.
- `core_irq_ack_i`  in  1  core entered trap handler.
- `core_mret_i`  in  1  single-cycle pulse; core executed mret.
- `mil_o`  out  8  current interrupt level.
- `nest_depth_o`  out  $clog2(STACK_DEPTH+1)  occupied stack entries.
- `err_o`  out  1  sticky; mret with empty stack.

## Operation
- FSM states: IDLE, PEND.
- Eligible = `irq_valid_i` && `irq_level_i > max(mil, mintthresh_i)` && `nest_depth_o < STACK_DEPTH`; unsigned 8-bit compares.
- IDLE: `irq_ready_o = eligible`, combinational. On handshake (valid && ready), latch id/level/shv and go to PEND.
- PEND: `irq_ready_o = 0`. `core_irq_req_o = 1` with stable latched fields until `core_irq_ack_i`.
- PEND + ack: push `mil` onto the stack, `mil <= latched level`, depth+1, return to IDLE.
- A request in PEND is never withdrawn, even if `mintthresh_i` rises or `irq_valid_i` drops.
- `core_mret_i` in any state: if depth>0, `mil <=` stack top and depth−1. If depth==0, `mil` stays unchanged and `err_o <= 1`.
- Same-cycle mret and ack in PEND: apply the pop first, then the push. Net effect: depth unchanged, top replaced by the popped level, `mil <=` latched level.
- `irq_valid_i` low in IDLE: no action. The id/level inputs are don't-care.
- Stack full: `irq_ready_o` stays 0 until an mret.

## Timing
- Reset values: `irq_ready_o` 0 (combinational, follows IDLE and eligible), `core_irq_req_o` 0, `core_irq_id_o` 0, `core_irq_level_o` 0, `core_irq_shv_o` 0, `mil_o` 0, `nest_depth_o` 0, `err_o` 0. FSM resets to IDLE and the stack is cleared.
- Latency: handshake at edge N, then `core_irq_req_o` high from cycle N+1.
- Ack sampled at edge M: `core_irq_req_o` low, `mil_o` updated, and `nest_depth_o` updated from cycle M+1. The earliest next handshake is also in cycle M+1.
- mret at edge K: `mil_o` and depth updated from K+1, and eligibility re-evaluated with the new `mil` in cycle K+1.
- Reset mid-operation: an asynchronous clear drops a pending request immediately, with no ack required.
- `err_o` clears only on reset.

## Test plan
- Reset, `mintthresh_i=0`, `irq_valid_i=1` id=5 level=8'h40 → `irq_ready_o=1` same cycle; next cycle `core_irq_req_o=1` id=5 level=8'h40; ack → `mil_o=8'h40`, depth=1.
- With `mil=8'h40`, request level 8'h40 then 8'h30 → `irq_ready_o` stays 0; level 8'h80 → accepted; after ack `mil=8'h80`, depth=2; mret → `mil=8'h40`, depth=1; mret → `mil=0`, depth=0.
- `mintthresh_i=8'hA0`, level 8'h90 → not accepted; level 8'hA1 → accepted.
- `STACK_DEPTH=4`: accept and ack levels 8'h10, 8'h20, 8'h30, 8'h40, then request 8'hF0 → `irq_ready_o=0` until mret, then accepted.
- In PEND for level 8'h80 with depth=1, assert mret and ack in the same cycle → depth=1, `mil=8'h80`; next mret → `mil=0`.
- mret at depth=0 → `err_o=1` and sticky; assert `rst_n=0` while `core_irq_req_o=1` → all outputs 0 immediately.

Source files
------------

// File: rtl/clic_irq_target.sv
// Core-side CLIC interrupt receiver: filters requests against mil/threshold,
// hands them to the hart with req/ack, and tracks preemption nesting on a level stack.
//
// state | meaning
// IDLE  | waiting for an eligible request from clic
// PEND  | request latched and presented to the core until ack
module clic_irq_target #(
    parameter int N_SOURCE    = 256,
    parameter int SRC_W       = $clog2(N_SOURCE),
    parameter int STACK_DEPTH = 4,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               irq_valid_i,
    output logic               irq_ready_o,
    input  logic [SRC_W-1:0]   irq_id_i,
    input  logic [7:0]         irq_level_i,
    input  logic               irq_shv_i,
    input  logic [7:0]         mintthresh_i,
    output logic               core_irq_req_o,
    output logic [SRC_W-1:0]   core_irq_id_o,
    output logic [7:0]         core_irq_level_o,
    output logic               core_irq_shv_o,
    input  logic               core_irq_ack_i,
    input  logic               core_mret_i,
    output logic [7:0]         mil_o,
    output logic [DEPTH_W-1:0] nest_depth_o,
    output logic               err_o
);

    typedef enum logic {IDLE, PEND} state_e;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   id_q, id_d;
    logic [7:0]         level_q, level_d;
    logic               shv_q, shv_d;
    logic [7:0]         mil_q, mil_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [7:0]         stack_q [STACK_DEPTH];
    logic [7:0]         stack_d [STACK_DEPTH];

    logic [7:0]         stack_top;
    logic               eligible;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        level_d = level_q;
        shv_d   = shv_q;
        mil_d   = mil_q;
        depth_d = depth_q;
        err_d   = err_q;
        stack_d = stack_q;

        stack_top = 8'h00;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) stack_top = stack_q[i];
        end

        eligible = irq_valid_i && (irq_level_i > mil_q) && (irq_level_i > mintthresh_i)
                   && (depth_q < DEPTH_FULL);
        irq_ready_o = (state_q == IDLE) && eligible;

        // The pop is applied first so a same-cycle ack pushes the restored level.
        if (core_mret_i) begin
            if (depth_q != '0) begin
                mil_d   = stack_top;
                depth_d = depth_q - 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (irq_ready_o) begin
                    id_d    = irq_id_i;
                    level_d = irq_level_i;
                    shv_d   = irq_shv_i;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (core_irq_ack_i) begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (DEPTH_W'(i) == depth_d) stack_d[i] = mil_d;
                    end
                    mil_d   = level_q;
                    depth_d = depth_d + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            level_q <= '0;
            shv_q   <= 1'b0;
            mil_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            level_q <= level_d;
            shv_q   <= shv_d;
            mil_q   <= mil_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            stack_q <= stack_d;
        end
    end

    assign core_irq_req_o   = (state_q == PEND);
    assign core_irq_id_o    = id_q;
    assign core_irq_level_o = level_q;
    assign core_irq_shv_o   = shv_q;
    assign mil_o            = mil_q;
    assign nest_depth_o     = depth_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_clic_irq_target.sv
// Directed bench for clic_irq_target: filtering, nesting, stack-full, mret/ack overlap, error and reset.
module tb_clic_irq_target;

    localparam int SRC_W   = 8;
    localparam int DEPTH_W = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               irq_valid_i;
    logic               irq_ready_o;
    logic [SRC_W-1:0]   irq_id_i;
    logic [7:0]         irq_level_i;
    logic               irq_shv_i;
    logic [7:0]         mintthresh_i;
    logic               core_irq_req_o;
    logic [SRC_W-1:0]   core_irq_id_o;
    logic [7:0]         core_irq_level_o;
    logic               core_irq_shv_o;
    logic               core_irq_ack_i;
    logic               core_mret_i;
    logic [7:0]         mil_o;
    logic [DEPTH_W-1:0] nest_depth_o;
    logic               err_o;

    int checks   = 0;
    int failures = 0;

    clic_irq_target dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq_valid_i      (irq_valid_i),
        .irq_ready_o      (irq_ready_o),
        .irq_id_i         (irq_id_i),
        .irq_level_i      (irq_level_i),
        .irq_shv_i        (irq_shv_i),
        .mintthresh_i     (mintthresh_i),
        .core_irq_req_o   (core_irq_req_o),
        .core_irq_id_o    (core_irq_id_o),
        .core_irq_level_o (core_irq_level_o),
        .core_irq_shv_o   (core_irq_shv_o),
        .core_irq_ack_i   (core_irq_ack_i),
        .core_mret_i      (core_mret_i),
        .mil_o            (mil_o),
        .nest_depth_o     (nest_depth_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_valid_i = 1'b0; irq_id_i = '0; irq_level_i = '0; irq_shv_i = 1'b0;
        mintthresh_i = '0; core_irq_ack_i = 1'b0; core_mret_i = 1'b0;
        #12;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0h exp=0", irq_ready_o); end
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", core_irq_req_o); end
        checks++; if (core_irq_id_o !== 8'h00) begin failures++; $display("FAIL rst_id got=%0h exp=0", core_irq_id_o); end
        checks++; if (core_irq_level_o !== 8'h00) begin failures++; $display("FAIL rst_level got=%0h exp=0", core_irq_level_o); end
        checks++; if (core_irq_shv_o !== 1'b0) begin failures++; $display("FAIL rst_shv got=%0h exp=0", core_irq_shv_o); end
        checks++; if (mil_o !== 8'h00) begin failures++; $display("FAIL rst_mil got=%0h exp=0", mil_o); end
        checks++; if (nest_depth_o !== 3'd0) begin failures++; $display("FAIL rst_depth got=%0h exp=0", nest_depth_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", err_o); end
        @(posedge clk); #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        irq_valid_i = 1'b1; irq_id_i = 8'd5; irq_level_i = 8'h40; irq_shv_i = 1'b1;
        #1;
        checks++; if (irq_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0h exp=1", irq_ready_o); end
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL basic_req_early got=%0h exp=0", core_irq_req_o); end
        step();
        // Keep an even higher request on the bus: PEND must not accept it.
        irq_id_i = 8'd9; irq_level_i = 8'hF0; irq_shv_i = 1'b0;
        #1;
        checks++; if (core_irq_req_o !== 1'b1) begin failures++; $display("FAIL basic_req got=%0h exp=1", core_irq_req_o); end
        checks++; if (core_irq_id_o !== 8'd5) begin failures++; $display("FAIL basic_id got=%0h exp=5", core_irq_id_o); end
        checks++; if (core_irq_level_o !== 8'h40) begin failures++; $display("FAIL basic_level got=%0h exp=40", core_irq_level_o); end
        checks++; if (core_irq_shv_o !== 1'b1) begin failures++; $display("FAIL basic_shv got=%0h exp=1", core_irq_shv_o); end
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL basic_pend_ready got=%0h exp=0", irq_ready_o); end
        // Request is never withdrawn, even when the threshold rises and valid drops.
        irq_valid_i = 1'b0; mintthresh_i = 8'hFF;
        step(); step();
        checks++; if (core_irq_req_o !== 1'b1) begin failures++; $display("FAIL basic_hold_req got=%0h exp=1", core_irq_req_o); end
        checks++; if (core_irq_level_o !== 8'h40) begin failures++; $display("FAIL basic_hold_level got=%0h exp=40", core_irq_level_o); end
        checks++; if (mil_o !== 8'h00) begin failures++; $display("FAIL basic_mil_preack got=%0h exp=0", mil_o); end
        mintthresh_i = 8'h00;
        core_irq_ack_i = 1'b1;
        step();
        core_irq_ack_i = 1'b0;
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL basic_req_after_ack got=%0h exp=0", core_irq_req_o); end
        checks++; if (mil_o !== 8'h40) begin failures++; $display("FAIL basic_mil got=%0h exp=40", mil_o); end
        checks++; if (nest_depth_o !== 3'd1) begin failures++; $display("FAIL basic_depth got=%0h exp=1", nest_depth_o); end
    endtask

    task automatic test_level_filter();
        irq_valid_i = 1'b1; irq_id_i = 8'd7; irq_level_i = 8'h40;
        #1;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL filt_equal got=%0h exp=0", irq_ready_o); end
        irq_level_i = 8'h30;
        #1;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL filt_lower got=%0h exp=0", irq_ready_o); end
        irq_level_i = 8'h80;
        #1;
        checks++; if (irq_ready_o !== 1'b1) begin failures++; $display("FAIL filt_higher got=%0h exp=1", irq_ready_o); end
        step();
        irq_valid_i = 1'b0;
        checks++; if (core_irq_level_o !== 8'h80) begin failures++; $display("FAIL filt_lat_level got=%0h exp=80", core_irq_level_o); end
        core_irq_ack_i = 1'b1;
        step();
        core_irq_ack_i = 1'b0;
        checks++; if (mil_o !== 8'h80) begin failures++; $display("FAIL filt_mil2 got=%0h exp=80", mil_o); end
        checks++; if (nest_depth_o !== 3'd2) begin failures++; $display("FAIL filt_depth2 got=%0h exp=2", nest_depth_o); end
        core_mret_i = 1'b1;
        step();
        core_mret_i = 1'b0;
        checks++; if (mil_o !== 8'h40) begin failures++; $display("FAIL filt_pop1_mil got=%0h exp=40", mil_o); end
        checks++; if (nest_depth_o !== 3'd1) begin failures++; $display("FAIL filt_pop1_depth got=%0h exp=1", nest_depth_o); end
        core_mret_i = 1'b1;
        step();
        core_mret_i = 1'b0;
        checks++; if (mil_o !== 8'h00) begin failures++; $display("FAIL filt_pop2_mil got=%0h exp=0", mil_o); end
        checks++; if (nest_depth_o !== 3'd0) begin failures++; $display("FAIL filt_pop2_depth got=%0h exp=0", nest_depth_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL filt_err got=%0h exp=0", err_o); end
    endtask

    task automatic test_threshold();
        mintthresh_i = 8'hA0; irq_valid_i = 1'b1; irq_level_i = 8'h90;
        #1;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL thr_below got=%0h exp=0", irq_ready_o); end
        irq_level_i = 8'hA0;
        #1;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL thr_equal got=%0h exp=0", irq_ready_o); end
        irq_level_i = 8'hA1;
        #1;
        checks++; if (irq_ready_o !== 1'b1) begin failures++; $display("FAIL thr_above got=%0h exp=1", irq_ready_o); end
        step();
        irq_valid_i = 1'b0;
        core_irq_ack_i = 1'b1;
        step();
        core_irq_ack_i = 1'b0;
        checks++; if (mil_o !== 8'hA1) begin failures++; $display("FAIL thr_mil got=%0h exp=a1", mil_o); end
        core_mret_i = 1'b1;
        step();
        core_mret_i = 1'b0;
        mintthresh_i = 8'h00;
        checks++; if (nest_depth_o !== 3'd0) begin failures++; $display("FAIL thr_depth got=%0h exp=0", nest_depth_o); end
    endtask

    task automatic test_stack_full();
        logic [7:0] lv [4];
        lv[0] = 8'h10; lv[1] = 8'h20; lv[2] = 8'h30; lv[3] = 8'h40;
        for (int i = 0; i < 4; i++) begin
            irq_valid_i = 1'b1; irq_level_i = lv[i]; irq_id_i = 8'(i + 20);
            #1;
            checks++; if (irq_ready_o !== 1'b1) begin failures++; $display("FAIL full_fill_ready[%0d] got=%0h exp=1", i, irq_ready_o); end
            step();
            irq_valid_i = 1'b0;
            core_irq_ack_i = 1'b1;
            step();
            core_irq_ack_i = 1'b0;
        end
        checks++; if (nest_depth_o !== 3'd4) begin failures++; $display("FAIL full_depth got=%0h exp=4", nest_depth_o); end
        checks++; if (mil_o !== 8'h40) begin failures++; $display("FAIL full_mil got=%0h exp=40", mil_o); end
        irq_valid_i = 1'b1; irq_level_i = 8'hF0; irq_id_i = 8'd99;
        #1;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL full_block got=%0h exp=0", irq_ready_o); end
        step(); step();
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL full_block_hold got=%0h exp=0", irq_ready_o); end
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL full_no_req got=%0h exp=0", core_irq_req_o); end
        core_mret_i = 1'b1;
        #1;
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL full_mret_same_cycle got=%0h exp=0", irq_ready_o); end
        step();
        core_mret_i = 1'b0;
        #1;
        checks++; if (irq_ready_o !== 1'b1) begin failures++; $display("FAIL full_after_mret got=%0h exp=1", irq_ready_o); end
        checks++; if (mil_o !== 8'h30) begin failures++; $display("FAIL full_pop_mil got=%0h exp=30", mil_o); end
        step();
        irq_valid_i = 1'b0;
        checks++; if (core_irq_id_o !== 8'd99) begin failures++; $display("FAIL full_lat_id got=%0h exp=63", core_irq_id_o); end
        core_irq_ack_i = 1'b1;
        step();
        core_irq_ack_i = 1'b0;
        checks++; if (mil_o !== 8'hF0) begin failures++; $display("FAIL full_refill_mil got=%0h exp=f0", mil_o); end
        checks++; if (nest_depth_o !== 3'd4) begin failures++; $display("FAIL full_refill_depth got=%0h exp=4", nest_depth_o); end
        for (int i = 3; i >= 0; i--) begin
            core_mret_i = 1'b1;
            step();
            core_mret_i = 1'b0;
            // Stack holds 00,10,20,30 below the current level.
            checks++; if (mil_o !== 8'(i * 16)) begin failures++; $display("FAIL full_unwind_mil[%0d] got=%0h exp=%0h", i, mil_o, 8'(i * 16)); end
        end
        checks++; if (nest_depth_o !== 3'd0) begin failures++; $display("FAIL full_unwind_depth got=%0h exp=0", nest_depth_o); end
    endtask

    task automatic test_mret_ack_same_cycle();
        irq_valid_i = 1'b1; irq_level_i = 8'h40;
        step();
        irq_valid_i = 1'b0;
        core_irq_ack_i = 1'b1;
        step();
        core_irq_ack_i = 1'b0;
        irq_valid_i = 1'b1; irq_level_i = 8'h80;
        step();
        irq_valid_i = 1'b0;
        checks++; if (core_irq_req_o !== 1'b1) begin failures++; $display("FAIL overlap_req got=%0h exp=1", core_irq_req_o); end
        checks++; if (nest_depth_o !== 3'd1) begin failures++; $display("FAIL overlap_pre_depth got=%0h exp=1", nest_depth_o); end
        core_irq_ack_i = 1'b1; core_mret_i = 1'b1;
        step();
        core_irq_ack_i = 1'b0; core_mret_i = 1'b0;
        checks++; if (nest_depth_o !== 3'd1) begin failures++; $display("FAIL overlap_depth got=%0h exp=1", nest_depth_o); end
        checks++; if (mil_o !== 8'h80) begin failures++; $display("FAIL overlap_mil got=%0h exp=80", mil_o); end
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL overlap_req_clr got=%0h exp=0", core_irq_req_o); end
        core_mret_i = 1'b1;
        step();
        core_mret_i = 1'b0;
        checks++; if (mil_o !== 8'h00) begin failures++; $display("FAIL overlap_pop_mil got=%0h exp=0", mil_o); end
        checks++; if (nest_depth_o !== 3'd0) begin failures++; $display("FAIL overlap_pop_depth got=%0h exp=0", nest_depth_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL overlap_err got=%0h exp=0", err_o); end
    endtask

    task automatic test_err_and_reset();
        core_mret_i = 1'b1;
        step();
        core_mret_i = 1'b0;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%0h exp=1", err_o); end
        checks++; if (mil_o !== 8'h00) begin failures++; $display("FAIL err_mil got=%0h exp=0", mil_o); end
        checks++; if (nest_depth_o !== 3'd0) begin failures++; $display("FAIL err_depth got=%0h exp=0", nest_depth_o); end
        irq_valid_i = 1'b1; irq_level_i = 8'h50; irq_id_i = 8'd33; irq_shv_i = 1'b1;
        step(); step();
        irq_valid_i = 1'b0;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0h exp=1", err_o); end
        checks++; if (core_irq_req_o !== 1'b1) begin failures++; $display("FAIL err_req got=%0h exp=1", core_irq_req_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL arst_req got=%0h exp=0", core_irq_req_o); end
        checks++; if (core_irq_id_o !== 8'h00) begin failures++; $display("FAIL arst_id got=%0h exp=0", core_irq_id_o); end
        checks++; if (core_irq_level_o !== 8'h00) begin failures++; $display("FAIL arst_level got=%0h exp=0", core_irq_level_o); end
        checks++; if (core_irq_shv_o !== 1'b0) begin failures++; $display("FAIL arst_shv got=%0h exp=0", core_irq_shv_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL arst_err got=%0h exp=0", err_o); end
        checks++; if (irq_ready_o !== 1'b0) begin failures++; $display("FAIL arst_ready got=%0h exp=0", irq_ready_o); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (core_irq_req_o !== 1'b0) begin failures++; $display("FAIL arst_release_req got=%0h exp=0", core_irq_req_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_filter();
        test_threshold();
        test_stack_full();
        test_mret_ack_same_cycle();
        test_err_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
